lap_sampler: RTL

Producer side of the sample stash interface. It debounces the raw lap push-button and, on a clean press while the stopwatch is running, captures the current 8-bit time value. It then drives it out as a registered sample with a one-cycle valid strobe. The outputs connect directly to the stash's sample_in / sample_in_valid inputs; lap_count feeds the display/LED logic.

---
 rtl/lap_pkg.sv | 12 +
 rtl/lap_sampler_btn_debounce.sv | 45 ++++
 rtl/lap_sampler.sv | 96 +++++++++
 3 files changed

// File: rtl/lap_pkg.sv
// Shared FSM encoding for the lap sampler; purely declarative, no latency or backpressure.
package lap_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 2'd0,
        WAIT_REL = 2'd1,
        HOLDOFF  = 2'd2
    } state_t;

endpackage

// File: rtl/lap_sampler_btn_debounce.sv
// Two-flop synchronizer plus stability counter; db follows btn_raw after DEBOUNCE_CYCLES+2 edges.
// No backpressure: db_rise is a single-cycle level-change indication.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic db,
    output logic db_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_1;
    logic             btn_s;
    logic             db_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            btn_s  <= 1'b0;
            db     <= 1'b0;
            db_d   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= btn_raw;
            btn_s  <= sync_1;
            db_d   <= db;
            if (btn_s == db) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                // The increment that would reach DEBOUNCE_CYCLES flips the level instead.
                db  <= ~db;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign db_rise = db & ~db_d;

endmodule

// File: rtl/lap_sampler.sv
// Debounced lap button -> registered time sample with one-cycle valid, DEBOUNCE_CYCLES+3 edges after press.
// No backpressure: the stash must accept every strobe. LAP_SAMPLER_STOP_CAPTURE_EN adds a sample on run stop.
module lap_sampler
    import lap_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLDOFF_CYCLES  = 8,
    parameter int DEPTH           = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       btn_lap,
    input  logic                       running,
    input  logic [7:0]                 time_in,
    input  logic                       clear,
    output logic [7:0]                 sample_out,
    output logic                       sample_valid,
    output logic [$clog2(DEPTH+1)-1:0] lap_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    state_t          state;
    state_t          next_state;
    logic            db;
    logic            db_rise;
    logic            btn_emit;
    logic            emit;
    logic [HW-1:0]   ho_cnt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_lap),
        .db      (db),
        .db_rise (db_rise)
    );

    always_comb begin
        next_state = state;
        btn_emit   = 1'b0;
        case (state)
            IDLE: begin
                if (db_rise) begin
                    next_state = WAIT_REL;
                    btn_emit   = running;
                end
            end
            WAIT_REL: begin
                if (!db) next_state = HOLDOFF;
            end
            HOLDOFF: begin
                // Presses landing here are dropped; the dead time is never extended.
                if (ho_cnt == HW'(HOLDOFF_CYCLES - 1)) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef LAP_SAMPLER_STOP_CAPTURE_EN
    logic running_d;

    always_ff @(posedge clk) begin
        if (!reset) running_d <= 1'b0;
        else        running_d <= running;
    end

    assign emit = btn_emit | (running_d & ~running);
`else
    assign emit = btn_emit;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            ho_cnt       <= '0;
            sample_out   <= 8'h00;
            sample_valid <= 1'b0;
            lap_count    <= '0;
        end else begin
            state        <= next_state;
            sample_valid <= emit;
            if (state == HOLDOFF) ho_cnt <= ho_cnt + 1'b1;
            else                  ho_cnt <= '0;
            if (emit) sample_out <= time_in;
            if (clear)
                lap_count <= '0;
            else if (emit && lap_count < CW'(DEPTH))
                lap_count <= lap_count + 1'b1;
        end
    end

endmodule
